// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, in-order imem requests, prefetch FIFO, redirect/stall
// Credits (inflight + buffered) bound outstanding requests so every returning word has a FIFO slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight, drop, count;
    logic [31:0]   pcq [FIFO_DEPTH];
    logic [AW-1:0] pcq_wr, pcq_rd;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic          accept, push, pop;
    logic [CW:0]   credits;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count_next, remain;
    logic [AW-1:0] rd_next;
    logic [31:0]   head_data, head_pc;
    logic          unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign credits         = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid  = reset_n && !redirect_valid && (credits < DEPTH_C);
    assign imem_req_addr   = fetch_pc;
    assign accept          = imem_req_valid && imem_req_ready;
    assign pop             = instr_valid && !stall;
    assign push            = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign rsp_pc          = pcq[pcq_rd];

    // The output registers always load what the FIFO head will be after this edge.
    always_comb begin
        rd_next    = rd_ptr + AW'(pop);
        remain     = count - CW'(pop);
        count_next = redirect_valid ? '0 : (remain + CW'(push));
        if (remain == '0) begin
            head_data = imem_rsp_data;
            head_pc   = rsp_pc;
        end else begin
            head_data = fifo_data[rd_next];
            head_pc   = fifo_pc[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= '0;
            drop        <= '0;
            count       <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            instr_valid <= 1'b0;
            instruction <= NOP;
            pc_out      <= RESET_PC;
        end else begin
            if (accept)
                pcq_wr <= pcq_wr + AW'(1);
            if (imem_rsp_valid)
                pcq_rd <= pcq_rd + AW'(1);
            inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                drop     <= inflight - CW'(imem_rsp_valid);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && drop != '0)
                    drop <= drop - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                rd_ptr <= rd_next;
            end
            count       <= count_next;
            instr_valid <= (count_next != '0);
            instruction <= (count_next != '0) ? head_data : NOP;
            if (count_next != '0)
                pc_out <= head_pc;
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(imem_rsp_valid && inflight == '0));
    assert property (@(posedge clk) disable iff (!reset_n) !(push && count == FULL_C && !pop));
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with an in-order fixed-latency memory model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, stall, instr_valid;
    logic [31:0] redirect_pc, instruction, pc_out;

    logic        rv2, ready2, rsp_valid2, redir2, stall2, iv2;
    logic [31:0] ra2, rsp_data2, redir_pc2, ins2, pc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instruction(instruction), .pc_out(pc_out)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(rv2), .imem_req_addr(ra2), .imem_req_ready(ready2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .redirect_valid(redir2), .redirect_pc(redir_pc2), .stall(stall2),
        .instr_valid(iv2), .instruction(ins2), .pc_out(pc2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: accept in cycle N -> response in cycle N+lat, in order.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;
    logic  acc_s = 1'b0;
    logic [31:0] addr_s = '0;

    always @(negedge clk) begin
        acc_s  = reset_n && imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
    end

    always @(posedge clk) begin
        if (!reset_n)
            mq.delete();
        else if (acc_s)
            mq.push_back('{addr: addr_s, due: cyc + lat});
        cyc++;
        #1;
        if (reset_n && mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        lat            = l;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        exp_rv;
        logic [31:0] exp_ra;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vt[$];

    function automatic void add(input logic s, input logic rv, input logic [31:0] ra,
                                input logic iv, input logic [31:0] pc);
        vt.push_back('{stall: s, exp_rv: rv, exp_ra: ra, exp_iv: iv, exp_pc: pc});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp2 [3];
        logic [31:0] exp_pc;
        int n, got_n, first_cyc;

        exp2[0] = 32'hFFFF_FFF8; exp2[1] = 32'hFFFF_FFFC; exp2[2] = 32'h0000_0000;

        // 1-cycle memory: streaming, then a 10-cycle stall (cycles 6..15) filling all 4 entries
        add(0, 1, 32'd0,  0, 32'd0);
        add(0, 1, 32'd4,  0, 32'd0);
        add(0, 1, 32'd8,  1, 32'd0);
        add(0, 1, 32'd12, 1, 32'd4);
        add(0, 1, 32'd16, 1, 32'd8);
        add(0, 1, 32'd20, 1, 32'd12);
        add(1, 1, 32'd24, 1, 32'd16);
        add(1, 1, 32'd28, 1, 32'd16);
        for (int k = 8; k <= 15; k++) add(1, 0, 32'd32, 1, 32'd16);
        add(0, 0, 32'd32, 1, 32'd16);
        add(0, 1, 32'd32, 1, 32'd20);
        add(0, 1, 32'd36, 1, 32'd24);
        add(0, 1, 32'd40, 1, 32'd28);
        add(0, 1, 32'd44, 1, 32'd32);
        add(0, 1, 32'd48, 1, 32'd36);

        ready2 = 1'b1; rsp_valid2 = 1'b0; rsp_data2 = '0;
        redir2 = 1'b0; redir_pc2 = '0; stall2 = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        reset_n = 1'b0;

        // reset state
        @(negedge clk);
        chk("reset req_valid", imem_req_valid, 0);
        chk("reset instr_valid", instr_valid, 0);
        chk("reset instruction", instruction, 32'h0000_0013);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset dut2 pc_out", pc2, 32'hFFFF_FFF8);
        chk("reset dut2 req_valid", rv2, 0);

        do_reset(1);
        for (int i = 0; i < vt.size(); i++) begin
            stall = vt[i].stall;
            @(negedge clk);
            chk($sformatf("vec%0d req_valid", i), imem_req_valid, vt[i].exp_rv);
            chk($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].exp_ra);
            chk($sformatf("vec%0d instr_valid", i), instr_valid, vt[i].exp_iv);
            chk($sformatf("vec%0d pc_out", i), pc_out, vt[i].exp_pc);
            chk($sformatf("vec%0d instruction", i), instruction,
                vt[i].exp_iv ? mem_word(vt[i].exp_pc) : 32'h0000_0013);
            if (i < 3) chk($sformatf("wrap addr%0d", i), ra2, exp2[i]);
            if (i == 4) chk("wrap credits exhausted", rv2, 0);
            step();
        end

        // redirect with 3 requests in flight, misaligned target
        do_reset(4);
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("redir req_valid low", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        chk("redir new addr", imem_req_addr, 32'h100);
        chk("redir new req_valid", imem_req_valid, 1);
        n = 4;
        while (!instr_valid && n < 24) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("redir first valid", instr_valid, 1);
        chk("redir first cycle", n, 9);
        chk("redir first pc", pc_out, 32'h100);
        chk("redir first instr", instruction, mem_word(32'h100));

        // redirect coinciding with a response while stalled
        do_reset(1);
        repeat (6) step();
        stall = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("stallredir held pc", pc_out, 32'd16);
        step();
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        chk("stallredir flushed", instr_valid, 0);
        chk("stallredir nop", instruction, 32'h0000_0013);
        chk("stallredir req_valid", imem_req_valid, 1);
        chk("stallredir addr", imem_req_addr, 32'h200);
        step();
        @(negedge clk);
        chk("stallredir still empty", instr_valid, 0);
        step();
        @(negedge clk);
        chk("stallredir valid", instr_valid, 1);
        chk("stallredir pc", pc_out, 32'h200);
        step();
        @(negedge clk);
        chk("stallredir held", pc_out, 32'h200);
        chk("stallredir held instr", instruction, mem_word(32'h200));

        // reset asserted mid-stream with requests in flight
        do_reset(4);
        repeat (5) step();
        @(negedge clk);
        chk("midrst pre valid", instr_valid, 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst instr_valid", instr_valid, 0);
        chk("midrst instruction", instruction, 32'h0000_0013);
        chk("midrst pc_out", pc_out, 32'h0);
        chk("midrst req_valid", imem_req_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        got_n = 0; first_cyc = -1; exp_pc = '0;
        for (int c = 0; c < 30 && got_n < 3; c++) begin
            @(negedge clk);
            if (c == 0) chk("midrst restart addr", imem_req_addr, 32'h0);
            if (instr_valid) begin
                if (got_n == 0) first_cyc = c;
                chk($sformatf("midrst pc%0d", got_n), pc_out, exp_pc);
                chk($sformatf("midrst instr%0d", got_n), instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got_n++;
            end
            step();
        end
        chk("midrst delivered", got_n, 3);
        chk("midrst first cycle", first_cyc, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
